// File: rtl/multu_unit_pkg.sv
// Shared definitions for the EX-stage unsigned multiplier.
// The EX mux and hazard unit use the same state encoding and default width.
package multu_unit_pkg;

    localparam int MULTU_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } multu_state_e;

endpackage

// File: rtl/multu_unit_hilo_reg.sv
// HI/LO register pair with write enable.
// Kept separate so future MTHI/MTLO support can share it.
module multu_unit_hilo_reg #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               we_i,
    input  logic [2*WIDTH-1:0] prod_i,
    output logic [WIDTH-1:0]   hi_o,
    output logic [WIDTH-1:0]   lo_o
);

    logic [2*WIDTH-1:0] hilo_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            hilo_q <= '0;
        end else if (we_i) begin
            hilo_q <= prod_i;
        end
    end

    assign hi_o = hilo_q[2*WIDTH-1:WIDTH];
    assign lo_o = hilo_q[WIDTH-1:0];

endmodule

// File: rtl/multu_unit.sv
// Multi-cycle radix-2 shift-add unsigned multiplier for the EX stage.
// Stalls ID/EX while running and commits the product to HI/LO on the final iteration.
module multu_unit
    import multu_unit_pkg::*;
#(
    parameter int WIDTH      = MULTU_WIDTH,
    parameter bit EARLY_EXIT = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             flush,
    output logic             stall,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int PW = 2 * WIDTH;

    multu_state_e   state_q, state_d;
    logic [PW-1:0]    mcand_q, mcand_d;
    logic [PW-1:0]    acc_q, acc_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic [PW-1:0]    accSum;
    logic [WIDTH-1:0] mplierShifted;
    logic             lastIter;
    logic             hiloWe;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            mcand_q  <= '0;
            acc_q    <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            acc_q    <= acc_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
        end
    end

    // accSum already includes this cycle's add, so it is also the value committed to HI/LO.
    always_comb begin
        accSum        = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
        mplierShifted = mplier_q >> 1;
        lastIter      = (cnt_q == CW'(WIDTH - 1)) ||
                        (EARLY_EXIT && (mplierShifted == '0));

        state_d  = state_q;
        mcand_d  = mcand_q;
        acc_d    = acc_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        hiloWe   = 1'b0;

        case (state_q)
            IDLE: begin
                if (start && !flush) begin
                    mcand_d  = {{WIDTH{1'b0}}, op_a};
                    mplier_d = op_b;
                    acc_d    = '0;
                    cnt_d    = '0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                if (flush) begin
                    state_d = IDLE;
                end else begin
                    acc_d    = accSum;
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplierShifted;
                    cnt_d    = cnt_q + 1'b1;
                    if (lastIter) begin
                        state_d = DONE;
                        hiloWe  = 1'b1;
                    end
                end
            end
            // The held MULTU is still in ID/EX here, so start must not re-trigger.
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    multu_unit_hilo_reg #(
        .WIDTH(WIDTH)
    ) u_hilo (
        .clk   (clk),
        .rst   (rst),
        .we_i  (hiloWe),
        .prod_i(accSum),
        .hi_o  (hi),
        .lo_o  (lo)
    );

    assign stall = !rst && (((state_q == IDLE) && start && !flush) || (state_q == RUN));
    assign busy  = (state_q == RUN);
    assign done  = (state_q == DONE);

endmodule

// File: tb/tb_multu_unit.sv
// Self-checking bench for multu_unit: table of directed multiplies on a normal and
// an early-exit instance, plus hand-written reset, flush and back-to-back sequences.
module tb_multu_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start0 = 1'b0;
    logic        start1 = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] opA = '0;
    logic [31:0] opB = '0;

    logic        stall0, busy0, done0;
    logic [31:0] hi0, lo0;
    logic        stall1, busy1, done1;
    logic [31:0] hi1, lo1;

    int errors = 0;
    int checks = 0;

    typedef struct {
        bit          ee;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] expHi;
        logic [31:0] expLo;
        int          expDone;
    } vec_t;

    vec_t vecs[9];

    multu_unit #(.WIDTH(32), .EARLY_EXIT(1'b0)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .op_a(opA), .op_b(opB), .flush(flush),
        .stall(stall0), .busy(busy0), .done(done0), .hi(hi0), .lo(lo0)
    );

    multu_unit #(.WIDTH(32), .EARLY_EXIT(1'b1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .op_a(opA), .op_b(opB), .flush(flush),
        .stall(stall1), .busy(busy1), .done(done1), .hi(hi1), .lo(lo1)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Starts a multiply at #1 after a posedge (cycle 0) and keeps start held while the
    // pipeline is stalled; returns at #1 after the DONE-cycle edge with start still high.
    task automatic applyStimulus(input bit ee, input logic [31:0] a, input logic [31:0] b,
                                 output int doneCyc, output int stallCnt);
        int cyc;
        if (ee) start1 = 1'b1; else start0 = 1'b1;
        opA = a;
        opB = b;
        cyc = 0;
        stallCnt = 0;
        doneCyc = -1;
        while (cyc < 100 && doneCyc < 0) begin
            @(negedge clk);
            if (ee ? stall1 : stall0) stallCnt++;
            if (ee ? done1 : done0) doneCyc = cyc;
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    initial begin
        int dc, sc, doneSeen;

        vecs[0] = '{1'b0, 32'd3,          32'd5,          32'h0000_0000, 32'h0000_000F, 33};
        vecs[1] = '{1'b0, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE, 32'h0000_0001, 33};
        vecs[2] = '{1'b0, 32'h8000_0000,  32'd2,          32'h0000_0001, 32'h0000_0000, 33};
        vecs[3] = '{1'b1, 32'h8000_0000,  32'd2,          32'h0000_0001, 32'h0000_0000, 3};
        vecs[4] = '{1'b1, 32'd7,          32'd0,          32'h0000_0000, 32'h0000_0000, 2};
        vecs[5] = '{1'b0, 32'h0000_1234,  32'h0000_5678,  32'h0000_0000, 32'h0626_0060, 33};
        vecs[6] = '{1'b1, 32'h1234_5678,  32'h0000_0010,  32'h0000_0001, 32'h2345_6780, 6};
        vecs[7] = '{1'b0, 32'h0000_0000,  32'hFFFF_FFFF,  32'h0000_0000, 32'h0000_0000, 33};
        vecs[8] = '{1'b1, 32'hFFFF_FFFF,  32'h8000_0000,  32'h7FFF_FFFF, 32'h8000_0000, 33};

        // Reset: stall must be forced low even with a pending start.
        start0 = 1'b1;
        opA = 32'd9;
        opB = 32'd9;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_stall_forced", {63'd0, stall0}, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        start0 = 1'b0;
        @(negedge clk);
        checkOutput("reset_busy", {63'd0, busy0}, 64'd0);
        checkOutput("reset_done", {63'd0, done0}, 64'd0);
        checkOutput("reset_hilo", {hi0, lo0}, 64'd0);
        checkOutput("reset_hilo_ee", {hi1, lo1}, 64'd0);

        // Start together with flush in IDLE is ignored.
        @(posedge clk);
        #1;
        start0 = 1'b1;
        flush = 1'b1;
        @(negedge clk);
        checkOutput("idle_flush_stall", {63'd0, stall0}, 64'd0);
        @(posedge clk);
        #1;
        start0 = 1'b0;
        flush = 1'b0;
        @(negedge clk);
        checkOutput("idle_flush_busy", {63'd0, busy0}, 64'd0);
        @(posedge clk);
        #1;

        for (int i = 0; i < 9; i++) begin
            applyStimulus(vecs[i].ee, vecs[i].a, vecs[i].b, dc, sc);
            start0 = 1'b0;
            start1 = 1'b0;
            checkOutput($sformatf("vec%0d_done_cycle", i), 64'(dc), 64'(vecs[i].expDone));
            checkOutput($sformatf("vec%0d_stall_cycles", i), 64'(sc), 64'(vecs[i].expDone));
            checkOutput($sformatf("vec%0d_hi", i), {32'd0, vecs[i].ee ? hi1 : hi0}, {32'd0, vecs[i].expHi});
            checkOutput($sformatf("vec%0d_lo", i), {32'd0, vecs[i].ee ? lo1 : lo0}, {32'd0, vecs[i].expLo});
        end

        // Back-to-back: start stays high through DONE; the second op is accepted in IDLE.
        applyStimulus(1'b0, 32'd4, 32'd4, dc, sc);
        checkOutput("b2b_first_done_cycle", 64'(dc), 64'd33);
        checkOutput("b2b_first_lo", {32'd0, lo0}, 64'd16);
        applyStimulus(1'b0, 32'd6, 32'd6, dc, sc);
        start0 = 1'b0;
        checkOutput("b2b_second_done_cycle", 64'(dc), 64'd33);
        checkOutput("b2b_second_stall_cycles", 64'(sc), 64'd33);
        checkOutput("b2b_second_lo", {32'd0, lo0}, 64'd36);

        // Reset at RUN cycle 10 aborts the multiply and clears HI/LO.
        start0 = 1'b1;
        opA = 32'h1234;
        opB = 32'h5678;
        repeat (10) begin
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        checkOutput("midrun_busy_before_reset", {63'd0, busy0}, 64'd1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        checkOutput("midrun_reset_stall", {63'd0, stall0}, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        start0 = 1'b0;
        @(negedge clk);
        checkOutput("midrun_reset_busy", {63'd0, busy0}, 64'd0);
        checkOutput("midrun_reset_stall_after", {63'd0, stall0}, 64'd0);
        checkOutput("midrun_reset_done", {63'd0, done0}, 64'd0);
        checkOutput("midrun_reset_hilo", {hi0, lo0}, 64'd0);
        @(posedge clk);
        #1;
        applyStimulus(1'b0, 32'd2, 32'd3, dc, sc);
        start0 = 1'b0;
        checkOutput("after_reset_done_cycle", 64'(dc), 64'd33);
        checkOutput("after_reset_lo", {32'd0, lo0}, 64'd6);

        // Flush at RUN cycle 5 returns to IDLE without touching HI/LO.
        applyStimulus(1'b0, 32'd3, 32'd5, dc, sc);
        start0 = 1'b0;
        checkOutput("preload_lo", {32'd0, lo0}, 64'd15);
        @(posedge clk);
        #1;
        start0 = 1'b1;
        opA = 32'd9;
        opB = 32'd9;
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        flush = 1'b1;
        start0 = 1'b0;
        @(posedge clk);
        #1;
        flush = 1'b0;
        @(negedge clk);
        checkOutput("flush_busy", {63'd0, busy0}, 64'd0);
        doneSeen = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (done0) doneSeen++;
        end
        checkOutput("flush_no_done", 64'(doneSeen), 64'd0);
        checkOutput("flush_hilo_kept", {hi0, lo0}, 64'd15);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/multu_unit.md
Name: multu_unit

Overview:
Multi-cycle unsigned multiplier in the EX stage. It is the consumer of the ID/EX register's multuOp_out, rd1_out and rd2_out fields. It accepts a MULTU request and computes the 64-bit product with a radix-2 shift-add datapath. While running it asserts stall, which drives the ID/EX en_reg low so the MULTU stays held in EX. When finished it commits the product to internal HI/LO registers, read by the EX result mux (total_alu_sel path).

Parameters:
WIDTH, 32, operand width; product is 2*WIDTH
EARLY_EXIT, 0, 1 = finish as soon as the remaining multiplier bits are all zero

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  multuOp_out from ID/EX; request a multiply
op_a  in  WIDTH  multiplicand (rd1_out)
op_b  in  WIDTH  multiplier (rd2_out)
flush  in  1  abort any in-flight multiply; HI/LO unchanged
stall  out  1  hold pipeline (to ID/EX en_reg, inverted by top level)
busy  out  1  state == RUN
done  out  1  one-cycle pulse: HI/LO just updated
hi  out  WIDTH  HI register
lo  out  WIDTH  LO register

Behaviour:
- Reset (rst=1 at posedge): state=IDLE; hi=0, lo=0, done=0, busy=0, counter=0, accumulator=0. stall is forced to 0 while rst=1. Reset wins over every other input, including mid-RUN; an aborted multiply never writes HI/LO.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 and flush=0: latch mcand = {WIDTH zeros, op_a} (2*WIDTH), mplier = op_b, acc = 0, cnt = 0; go to RUN.
  - start=1 and flush=1: ignore the request and stay in IDLE.
- RUN, each cycle:
  - If mplier[0], acc <= acc + mcand (2*WIDTH add, no carry-out; the product never overflows).
  - Then mcand <= mcand << 1, mplier <= mplier >> 1, cnt <= cnt + 1.
  - When cnt == WIDTH-1 (the last iteration), or when EARLY_EXIT=1 and the post-shift mplier == 0: go to DONE. On that same edge write {hi,lo} <= the final acc, including this cycle's add.
- DONE: done=1 for exactly this cycle; go to IDLE unconditionally. start is ignored in DONE, because the held MULTU is still in ID/EX during this cycle.
- flush=1 in RUN: go to IDLE next edge; no HI/LO write and no done pulse. flush in DONE has no effect, since HI/LO are already committed.
- stall (combinational) = !rst && ((state==IDLE && start && !flush) || state==RUN). It is deasserted in DONE, so ID/EX advances on the DONE-cycle edge.
- Latency with EARLY_EXIT=0: start seen in IDLE at cycle 0; RUN occupies cycles 1..WIDTH; done=1 in cycle WIDTH+1. stall is high for WIDTH+1 cycles (0..WIDTH).
- Back-to-back MULTU: the second one enters EX after DONE and is accepted in the following IDLE cycle. There is one bubble-free cycle between the two stall windows.
- hi/lo hold their values except on the commit edge; they are readable in any state.
- busy = (state==RUN); it is registered-state derived, with no combinational input path.

Decomposition:
- Shared package: state encoding constants (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and the WIDTH default, so the EX mux and hazard unit use the same values.
- No sub-module is needed. The optional split is a hilo_reg holding HI/LO with write enable and reset, reusable by future MTHI/MTLO support.

Test Plan:
- op_a=3, op_b=5, start held while stall=1 -> stall high for 33 cycles, done pulse in cycle 33, hi=0, lo=15.
- op_a=0xFFFFFFFF, op_b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001 after 33 cycles; product exactly fills 64 bits, no wrap.
- op_a=0x80000000, op_b=2; then op_a=7, op_b=0 with EARLY_EXIT=1 -> first gives hi=1, lo=0. Second gives done in cycle 2 (one RUN cycle), hi=0, lo=0, stall high for 2 cycles.
- rst asserted at RUN cycle 10 of a 0x1234*0x5678 multiply -> next cycle: state IDLE, stall=0, hi/lo=0, no done pulse; a new 2*3 then yields lo=6.
- Preload HI/LO with 3*5; then start 9*9 and assert flush at RUN cycle 5 -> return to IDLE, no done, hi=0, lo=15 retained.
- Two back-to-back MULTUs (4*4 then 6*6), start held by ID/EX -> two distinct done pulses separated by one IDLE-accept cycle; lo=16, then lo=36. No double-accept of the first op in DONE.
